display_timing_gen: RTL

- Parametrised successor to the fixed 640x480 display timing controller.
- Generates hs/vs, blanking and border flags, and line/frame strobes for any raster geometry, gated by a pixel clock enable.
- Emits look-ahead active flag and x/y coordinates with a configurable latency. The look-ahead is applied consistently on both axes, including across line and frame wrap.
- Sits between the pixel clock domain logic and the frame buffer read port / VGA pins.

---
 rtl/dtc_pkg.sv | 37 +++
 rtl/dtc_axis_counter.sv | 31 +++
 rtl/display_timing_gen.sv | 133 +++++++++++++
 3 files changed

// File: rtl/dtc_pkg.sv
// Shared types, stock raster geometries and helpers for the display timing generator.
package dtc_pkg;

    typedef enum logic [2:0] {
        SYNC, BACK_PORCH, BORDER_LO, ADDRESSABLE, BORDER_HI, FRONT_PORCH
    } dtc_region_e;

    typedef struct packed {
        int unsigned sync;
        int unsigned bp;
        int unsigned b0;
        int unsigned act;
        int unsigned b1;
        int unsigned fp;
    } dtc_axis_t;

    typedef struct packed {
        dtc_axis_t h;
        dtc_axis_t v;
    } dtc_timing_t;

    localparam dtc_timing_t VGA_640X480_60 = '{
        h: '{sync: 96,  bp: 40, b0: 8, act: 640, b1: 8, fp: 8},
        v: '{sync: 2,   bp: 25, b0: 8, act: 480, b1: 8, fp: 2}
    };

    localparam dtc_timing_t SVGA_800X600_60 = '{
        h: '{sync: 128, bp: 88, b0: 0, act: 800, b1: 0, fp: 40},
        v: '{sync: 4,   bp: 23, b0: 0, act: 600, b1: 0, fp: 1}
    };

    function automatic int total(input int sync, input int bp, input int b0,
                                 input int act, input int b1, input int fp);
        return sync + bp + b0 + act + b1 + fp;
    endfunction

endpackage

// File: rtl/dtc_axis_counter.sv
// ce-gated wrapping counter 0..TC-1; exposes the next-state value so callers can register from it.
module dtc_axis_counter
    import dtc_pkg::*;
#(
    parameter int W  = 11,
    parameter int TC = 800
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ce,
    output logic [W-1:0] cnt_nxt,
    output logic         wrap
);

    localparam logic [W-1:0] LAST = W'(TC - 1);

    logic [W-1:0] cnt;

    assign wrap = ce && (cnt == LAST);

    always_comb begin
        cnt_nxt = cnt;
        if (ce) cnt_nxt = wrap ? '0 : cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt <= '0;
        else      cnt <= cnt_nxt;
    end

endmodule

// File: rtl/display_timing_gen.sv
// Parametrised raster timing generator: syncs, blank/border, look-ahead x/y and line/frame strobes.
// Define DTC_FRAME_CTR_EN to add the 16-bit frame_cnt output.
module display_timing_gen
    import dtc_pkg::*;
#(
    parameter int CW     = 11,
    parameter int H_SYNC = VGA_640X480_60.h.sync,
    parameter int H_BP   = VGA_640X480_60.h.bp,
    parameter int H_LB   = VGA_640X480_60.h.b0,
    parameter int H_ACT  = VGA_640X480_60.h.act,
    parameter int H_RB   = VGA_640X480_60.h.b1,
    parameter int H_FP   = VGA_640X480_60.h.fp,
    parameter int V_SYNC = VGA_640X480_60.v.sync,
    parameter int V_BP   = VGA_640X480_60.v.bp,
    parameter int V_TB   = VGA_640X480_60.v.b0,
    parameter int V_ACT  = VGA_640X480_60.v.act,
    parameter int V_BB   = VGA_640X480_60.v.b1,
    parameter int V_FP   = VGA_640X480_60.v.fp,
    parameter bit HS_POL = 1'b0,
    parameter bit VS_POL = 1'b0,
    parameter int LAT    = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ce,
    output logic          hs,
    output logic          vs,
    output logic          blank,
    output logic          border,
    output logic          active_video_area,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          line_start,
    output logic          frame_start
`ifdef DTC_FRAME_CTR_EN
    ,
    output logic [15:0]   frame_cnt
`endif
);

    localparam int H_TOTAL = total(H_SYNC, H_BP, H_LB, H_ACT, H_RB, H_FP);
    localparam int V_TOTAL = total(V_SYNC, V_BP, V_TB, V_ACT, V_BB, V_FP);
    localparam int H_AS    = H_SYNC + H_BP + H_LB;
    localparam int V_AS    = V_SYNC + V_BP + V_TB;

    if (H_TOTAL > (1 << CW) || V_TOTAL > (1 << CW)) begin : g_chk_size
        $error("display_timing_gen: raster totals do not fit in CW bits");
    end
    if (LAT < 0 || LAT > 4 || LAT >= H_AS) begin : g_chk_lat
        $error("display_timing_gen: LAT must be 0..4 and below H_AS");
    end

    // One spare bit so bounds equal to 2^CW and h+LAT never overflow.
    typedef logic [CW:0]   ext_t;
    typedef logic [CW-1:0] cnt_t;

    localparam ext_t HT_C   = ext_t'(H_TOTAL);
    localparam ext_t VT_C   = ext_t'(V_TOTAL);
    localparam ext_t HSY_C  = ext_t'(H_SYNC);
    localparam ext_t VSY_C  = ext_t'(V_SYNC);
    localparam ext_t HBL_C  = ext_t'(H_SYNC + H_BP);
    localparam ext_t HBH_C  = ext_t'(H_TOTAL - H_FP);
    localparam ext_t VBL_C  = ext_t'(V_SYNC + V_BP);
    localparam ext_t VBH_C  = ext_t'(V_TOTAL - V_FP);
    localparam ext_t HAS_C  = ext_t'(H_AS);
    localparam ext_t HAE_C  = ext_t'(H_AS + H_ACT);
    localparam ext_t VAS_C  = ext_t'(V_AS);
    localparam ext_t VAE_C  = ext_t'(V_AS + V_ACT);
    localparam ext_t LAT_C  = ext_t'(LAT);

    cnt_t hn, vn;
    logic h_wrap, v_wrap;

    dtc_axis_counter #(.W(CW), .TC(H_TOTAL)) u_hcnt (
        .clk(clk), .rst(rst), .ce(ce), .cnt_nxt(hn), .wrap(h_wrap)
    );

    dtc_axis_counter #(.W(CW), .TC(V_TOTAL)) u_vcnt (
        .clk(clk), .rst(rst), .ce(h_wrap), .cnt_nxt(vn), .wrap(v_wrap)
    );

    ext_t he, ve, hl_sum, hl, vl;
    logic blank_n, addr_n, act_n;

    always_comb begin
        he     = {1'b0, hn};
        ve     = {1'b0, vn};
        hl_sum = he + LAT_C;
        hl     = hl_sum;
        vl     = ve;
        // Look-ahead past end of line lands on the following line (and frame).
        if (hl_sum >= HT_C) begin
            hl = hl_sum - HT_C;
            vl = (ve == VT_C - 1'b1) ? '0 : ve + 1'b1;
        end
        blank_n = !(he >= HBL_C && he < HBH_C && ve >= VBL_C && ve < VBH_C);
        addr_n  = he >= HAS_C && he < HAE_C && ve >= VAS_C && ve < VAE_C;
        act_n   = hl >= HAS_C && hl < HAE_C && vl >= VAS_C && vl < VAE_C;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hs                <= HS_POL;
            vs                <= VS_POL;
            blank             <= 1'b1;
            border            <= 1'b0;
            active_video_area <= 1'b0;
            x                 <= '0;
            y                 <= '0;
            line_start        <= 1'b0;
            frame_start       <= 1'b0;
        end else if (ce) begin
            hs                <= (he < HSY_C) ? HS_POL : !HS_POL;
            vs                <= (ve < VSY_C) ? VS_POL : !VS_POL;
            blank             <= blank_n;
            border            <= !blank_n && !addr_n;
            active_video_area <= act_n;
            x                 <= act_n ? cnt_t'(hl - HAS_C) : '0;
            y                 <= act_n ? cnt_t'(vl - VAS_C) : '0;
            // A wrap this cycle means the next position is h=0 (and v=0).
            line_start        <= h_wrap;
            frame_start       <= v_wrap;
        end
    end

`ifdef DTC_FRAME_CTR_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)              frame_cnt <= '0;
        else if (ce && v_wrap) frame_cnt <= frame_cnt + 1'b1;
    end
`endif

endmodule
